// File: rtl/prbs_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// prbs_checker: self-synchronising PRBS checker with lock FSM and error/bit
// counters; macro PRBS_CHECKER_BITCNT_EN builds o_bit_count. Rev 1.0
// ============================================================================
module prbs_checker #(
  parameter int NB         = 9,
  parameter int TAP_A      = 1,
  parameter int TAP_B      = 5,
  parameter int LOCK_CNT   = 16,
  parameter int WIN        = 64,
  parameter int UNLOCK_CNT = 8,
  parameter int CW         = 32
) (
  input  logic          clock,
  input  logic          i_reset_n,
  input  logic          i_enable,
  input  logic          i_valid,
  input  logic          i_data,
  input  logic          i_clear,
  output logic          o_locked,
  output logic          o_err,
  output logic [CW-1:0] o_err_count,
  output logic [CW-1:0] o_bit_count
);

  localparam int FW = $clog2(TAP_B + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int WW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int EW = $clog2(UNLOCK_CNT + 1);

  localparam logic [FW-1:0] FILL_MAX    = FW'(TAP_B);
  localparam logic [FW-1:0] FILL_ONE    = FW'(1);
  localparam logic [GW-1:0] GOOD_LAST   = GW'(LOCK_CNT - 1);
  localparam logic [GW-1:0] GOOD_ONE    = GW'(1);
  localparam logic [WW-1:0] WIN_LAST    = WW'(WIN - 1);
  localparam logic [WW-1:0] WIN_ONE     = WW'(1);
  localparam logic [EW-1:0] UNLOCK_LAST = EW'(UNLOCK_CNT - 1);
  localparam logic [EW-1:0] WERR_ONE    = EW'(1);
  localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [NB-1:0] hist_q, hist_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [GW-1:0] good_q, good_d;
  logic [WW-1:0] win_q, win_d;
  logic [EW-1:0] werr_q, werr_d;
  logic          err_q, err_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;

  logic w_accept, w_exp, w_mis;

  assign w_accept = i_enable & i_valid;
  assign w_exp    = hist_q[TAP_A-1] ^ hist_q[TAP_B-1];
  assign w_mis    = i_data ^ w_exp;

  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    good_d    = good_q;
    win_d     = win_q;
    werr_d    = werr_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    if (w_accept) begin
      case (state_q)
        SEARCH: begin
          hist_d = {hist_q[NB-2:0], i_data};
          if (fill_q != FILL_MAX) fill_d = fill_q + FILL_ONE;
          // An all-zero history would trivially predict zeros forever.
          if ((fill_q == FILL_MAX) && (hist_q != '0) && !w_mis) begin
            if (good_q == GOOD_LAST) begin
              state_d = LOCKED;
              good_d  = '0;
            end else begin
              good_d = good_q + GOOD_ONE;
            end
          end else begin
            good_d = '0;
          end
        end
        LOCKED: begin
          // Reference runs free so a flipped input bit is counted only once.
          hist_d = {hist_q[NB-2:0], w_exp};
          err_d  = w_mis;
          if (w_mis && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + CNT_ONE;
          if (w_mis && (werr_q == UNLOCK_LAST)) begin
            state_d = SEARCH;
            good_d  = '0;
            win_d   = '0;
            werr_d  = '0;
          end else if (win_q == WIN_LAST) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d = win_q + WIN_ONE;
            if (w_mis) werr_d = werr_q + WERR_ONE;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    if (i_clear) err_cnt_d = '0;
  end

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= SEARCH;
      hist_q    <= '0;
      fill_q    <= '0;
      good_q    <= '0;
      win_q     <= '0;
      werr_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      good_q    <= good_d;
      win_q     <= win_d;
      werr_q    <= werr_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_locked    = (state_q == LOCKED);
  assign o_err       = err_q;
  assign o_err_count = err_cnt_q;

`ifdef PRBS_CHECKER_BITCNT_EN
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (w_accept && (state_q == LOCKED) && (bit_cnt_q != CNT_MAX))
      bit_cnt_d = bit_cnt_q + CNT_ONE;
    if (i_clear) bit_cnt_d = '0;
  end

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) bit_cnt_q <= '0;
    else            bit_cnt_q <= bit_cnt_d;
  end

  assign o_bit_count = bit_cnt_q;
`else
  assign o_bit_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prbs_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_prbs_checker: directed scenarios with an error-pulse scoreboard. Rev 1.0
// ============================================================================
module tb_prbs_checker;

  localparam int CW = 32;
`ifdef PRBS_CHECKER_BITCNT_EN
  localparam bit BITCNT = 1'b1;
`else
  localparam bit BITCNT = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_enable = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_data = 1'b0;
  logic          i_clear = 1'b0;
  logic          o_locked;
  logic          o_err;
  logic [CW-1:0] o_err_count;
  logic [CW-1:0] o_bit_count;

  int       n_vec = 0;
  int       n_fail = 0;
  logic [8:0] g = 9'h1AA;
  int       sb_q[$];
  int       sb_cnt = 0;

  always #5 clock = ~clock;

  prbs_checker dut (
    .clock      (clock),
    .i_reset_n  (i_reset_n),
    .i_enable   (i_enable),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .i_clear    (i_clear),
    .o_locked   (o_locked),
    .o_err      (o_err),
    .o_err_count(o_err_count),
    .o_bit_count(o_bit_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] bc(input int n);
    return BITCNT ? 64'(n) : 64'd0;
  endfunction

  // Reference generator: output = g[0]^g[4], then shifted into g.
  task automatic gen_next(output logic b);
    b = g[0] ^ g[4];
    g = {g[7:0], b};
  endtask

  task automatic send(input logic d, input logic v, input logic clr);
    i_enable = 1'b1;
    i_valid  = v;
    i_data   = d;
    i_clear  = clr;
    @(posedge clock);
    #1;
    i_clear = 1'b0;
    i_valid = 1'b0;
  endtask

  task automatic good_bit();
    logic b;
    gen_next(b);
    send(b, 1'b1, 1'b0);
  endtask

  task automatic bad_bit(input logic clr);
    logic b;
    gen_next(b);
    if (clr) sb_cnt = 0;
    else     sb_cnt++;
    sb_q.push_back(sb_cnt);
    send(~b, 1'b1, clr);
  endtask

  // Called 1 ns after a rising edge; reset is asserted and released between edges.
  task automatic async_reset(input bit do_chk);
    #2;
    i_reset_n = 1'b0;
    #1;
    if (do_chk) begin
      chk("rst_locked", o_locked, 0);
      chk("rst_err", o_err, 0);
      chk("rst_errcnt", o_err_count, 0);
      chk("rst_bitcnt", o_bit_count, 0);
    end
    #2;
    i_reset_n = 1'b1;
    g      = 9'h1AA;
    sb_cnt = 0;
  endtask

  always @(negedge clock) begin
    int e;
    if (i_reset_n && (o_err === 1'b1)) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_err_pulse: got o_err=1 expected no pulse");
      end else begin
        e = sb_q.pop_front();
        chk("err_pulse_count", o_err_count, 64'(e));
      end
    end
  end

  initial begin
    logic max_lock;
    logic b;
    #1;
    async_reset(1'b1);

    // Lock on a clean stream
    for (int i = 1; i <= 21; i++) begin
      good_bit();
      if (i == 20) chk("s1_lock_after_20", o_locked, 0);
    end
    chk("s1_lock_after_21", o_locked, 1);
    repeat (979) good_bit();
    chk("s1_errcnt", o_err_count, 0);
    chk("s1_bitcnt", o_bit_count, bc(979));
    chk("s1_locked", o_locked, 1);

    // Single flipped bit
    bad_bit(1'b0);
    good_bit();
    chk("s2_errcnt", o_err_count, 1);
    chk("s2_locked", o_locked, 1);
    repeat (43) good_bit();
    chk("s2_bitcnt", o_bit_count, bc(1024));

    // Clear on a non-accepted cycle
    send(1'b0, 1'b0, 1'b1);
    sb_cnt = 0;
    chk("clr_errcnt", o_err_count, 0);
    chk("clr_bitcnt", o_bit_count, 0);
    chk("clr_locked", o_locked, 1);

    // Eight errors within one window force loss of lock
    for (int k = 1; k <= 8; k++) begin
      bad_bit(1'b0);
      if (k < 8) good_bit();
      if (k == 7) chk("s3_locked_after_7", o_locked, 1);
    end
    chk("s3_unlock", o_locked, 0);
    chk("s3_errcnt", o_err_count, 8);
    chk("s3_bitcnt", o_bit_count, bc(15));
    repeat (15) good_bit();
    chk("s3_relock_15", o_locked, 0);
    good_bit();
    chk("s3_relock_16", o_locked, 1);
    chk("s3_errcnt_hold", o_err_count, 8);
    chk("s3_bitcnt_hold", o_bit_count, bc(15));

    // All-zero input never locks
    async_reset(1'b0);
    max_lock = 1'b0;
    repeat (200) begin
      send(1'b0, 1'b1, 1'b0);
      if (o_locked !== 1'b0) max_lock = 1'b1;
    end
    chk("s4_never_locked", max_lock, 0);
    chk("s4_errcnt", o_err_count, 0);

    // i_valid toggling every cycle with garbage on idle cycles
    async_reset(1'b0);
    for (int acc = 1; acc <= 1000; acc++) begin
      gen_next(b);
      send(b, 1'b1, 1'b0);
      if (acc == 20) chk("s5_lock_after_20", o_locked, 0);
      if (acc == 21) chk("s5_lock_after_21", o_locked, 1);
      send(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (acc == 20)  chk("s5_idle_lock_20", o_locked, 0);
      if (acc == 500) chk("s5_idle_bitcnt", o_bit_count, bc(479));
    end
    chk("s5_errcnt", o_err_count, 0);
    chk("s5_bitcnt", o_bit_count, bc(979));

    // Clear coincident with an error, then asynchronous reset while locked
    bad_bit(1'b1);
    chk("s6_errcnt", o_err_count, 0);
    chk("s6_bitcnt", o_bit_count, 0);
    chk("s6_locked", o_locked, 1);
    good_bit();
    async_reset(1'b1);
    for (int i = 1; i <= 21; i++) begin
      good_bit();
      if (i == 20) chk("s6_relock_20", o_locked, 0);
    end
    chk("s6_relock_21", o_locked, 1);

    repeat (2) @(posedge clock);
    chk("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
